// File: rtl/vga_pkg.sv
// Shared definitions for the VGA timing controller: colour-source modes,
// 640x480@60 reference timing and the colour-bar lookup.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_MEM   = 2'b00,
    MODE_SOLID = 2'b01,
    MODE_BARS  = 2'b10,
    MODE_CHECK = 2'b11
  } vga_mode_e;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  // {R,G,B} on/off for bar index 0..7:
  // white, yellow, cyan, green, magenta, red, blue, black
  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    return {~idx[1], ~idx[2], ~idx[0]};
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-enable divider plus horizontal/vertical raster counters. Produces the
// raw active/sync conditions for the current counter position and a
// registered frame_start pulse for the request stage.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int CLK_DIV  = 1,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic          clock,
  input  logic          reset,
  output logic          pix_en,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic          active,
  output logic          hs_on,
  output logic          vs_on,
  output logic          frame_first,
  output logic          frame_start
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_cnt;
  logic          h_last;
  logic          v_last;

  assign pix_en = (div_cnt == DW'(CLK_DIV - 1));
  assign h_last = (h_cnt == HW'(H_TOTAL - 1));
  assign v_last = (v_cnt == VW'(V_TOTAL - 1));

  // Compares are done at 32 bits so sync windows ending at the total never overflow.
  assign active      = (32'(h_cnt) < H_ACTIVE) && (32'(v_cnt) < V_ACTIVE);
  assign hs_on       = (32'(h_cnt) >= H_ACTIVE + H_FP) && (32'(h_cnt) < H_ACTIVE + H_FP + H_SYNC);
  assign vs_on       = (32'(v_cnt) >= V_ACTIVE + V_FP) && (32'(v_cnt) < V_ACTIVE + V_FP + V_SYNC);
  assign frame_first = pix_en && (h_cnt == '0) && (v_cnt == '0);

  // Clock divider: pix_en on the last count of each CLK_DIV period.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       div_cnt <= '0;
    else if (pix_en) div_cnt <= '0;
    else             div_cnt <= div_cnt + DW'(1);
  end

  // Raster counters advance one pixel per pix_en; v steps on the h wrap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + VW'(1);
      end else begin
        h_cnt <= h_cnt + HW'(1);
      end
    end
  end

  // frame_start marks the request-stage tick of pixel (0,0).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) frame_start <= 1'b0;
    else       frame_start <= frame_first;
  end

endmodule

// File: rtl/vga_ctrl_gen.sv
// Parametrised VGA controller: issues pixel requests to vmem, builds the
// test-pattern colour, and delays control/pattern by DATA_LAT ticks so that
// every colour source reaches the pins with the same latency as vmem data.
module vga_ctrl_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = VGA_H_ACTIVE,
  parameter int H_FP      = VGA_H_FP,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BP      = VGA_H_BP,
  parameter int V_ACTIVE  = VGA_V_ACTIVE,
  parameter int V_FP      = VGA_V_FP,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BP      = VGA_V_BP,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CLK_DIV   = 1,
  parameter int DATA_LAT  = 1,
  parameter int COLOR_W   = 8,
  localparam int HAW      = $clog2(H_ACTIVE),
  localparam int VAW      = $clog2(V_ACTIVE),
  localparam int RGB_W    = 3 * COLOR_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [1:0]         mode,
  input  logic [RGB_W-1:0]   solid_rgb,
  input  logic [RGB_W-1:0]   vga_data,
  output logic [HAW-1:0]     h_addr,
  output logic [VAW-1:0]     v_addr,
  output logic               pix_req,
  output logic               frame_start,
  output logic               hsync,
  output logic               vsync,
  output logic               valid,
  output logic [COLOR_W-1:0] vga_r,
  output logic [COLOR_W-1:0] vga_g,
  output logic [COLOR_W-1:0] vga_b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int BCW     = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  // Delay-line word: {active, hsync_on, vsync_on, use_mem, pattern_rgb}
  localparam int DLW     = 4 + RGB_W;

  logic            pix_en;
  logic [HW-1:0]   h_cnt;
  logic [VW-1:0]   v_cnt;
  logic            active;
  logic            hs_on;
  logic            vs_on;
  logic            frame_first;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .CLK_DIV  (CLK_DIV)
  ) u_timing (
    .clock       (clock),
    .reset       (reset),
    .pix_en      (pix_en),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .active      (active),
    .hs_on       (hs_on),
    .vs_on       (vs_on),
    .frame_first (frame_first),
    .frame_start (frame_start)
  );

  vga_mode_e        mode_q;
  vga_mode_e        mode_cur;
  logic [BCW-1:0]   bar_col;
  logic [2:0]       bar_idx;
  logic [2:0]       bar_on;
  logic             h_in;
  logic             chk_on;
  logic             pat_mem;
  logic [RGB_W-1:0] pat_rgb;
  logic [DLW-1:0]   dl [0:DATA_LAT];
  logic [DLW-1:0]   tail;
  logic [RGB_W-1:0] rgb_q;

  // Pixel (0,0) already uses the newly sampled mode.
  assign mode_cur = frame_first ? vga_mode_e'(mode) : mode_q;
  assign h_in     = (32'(h_cnt) < H_ACTIVE);
  assign bar_on   = bar_rgb(bar_idx);
  assign chk_on   = |((32'(h_cnt) ^ 32'(v_cnt)) & 32'h20);
  assign tail     = dl[DATA_LAT];
  assign vga_r    = rgb_q[3*COLOR_W-1:2*COLOR_W];
  assign vga_g    = rgb_q[2*COLOR_W-1:COLOR_W];
  assign vga_b    = rgb_q[COLOR_W-1:0];

  // Colour source is latched once per frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)            mode_q <= MODE_MEM;
    else if (frame_first) mode_q <= vga_mode_e'(mode);
  end

  // Bar position tracks the column without a divider: count within a bar, step the index on overflow.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bar_col <= '0;
      bar_idx <= '0;
    end else if (pix_en) begin
      if (!h_in) begin
        bar_col <= '0;
        bar_idx <= '0;
      end else if (bar_col == BCW'(BAR_W - 1)) begin
        bar_col <= '0;
        bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_col <= bar_col + BCW'(1);
      end
    end
  end

  // Pattern colour for the pixel being requested this tick.
  always_comb begin
    pat_mem = 1'b0;
    pat_rgb = '0;
    case (mode_cur)
      MODE_MEM:   pat_mem = 1'b1;
      MODE_SOLID: pat_rgb = solid_rgb;
      MODE_BARS:  pat_rgb = {{COLOR_W{bar_on[2]}}, {COLOR_W{bar_on[1]}}, {COLOR_W{bar_on[0]}}};
      MODE_CHECK: pat_rgb = chk_on ? {RGB_W{1'b1}} : '0;
      default:    pat_rgb = '0;
    endcase
  end

  // pix_req is a one-clock strobe per active tick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) pix_req <= 1'b0;
    else       pix_req <= active & pix_en;
  end

  // Request stage (dl[0]) plus DATA_LAT shift stages, matching vmem latency.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h_addr <= '0;
      v_addr <= '0;
      for (int i = 0; i <= DATA_LAT; i++) dl[i] <= '0;
    end else if (pix_en) begin
      h_addr <= active ? h_cnt[HAW-1:0] : '0;
      v_addr <= active ? v_cnt[VAW-1:0] : '0;
      dl[0]  <= {active, hs_on, vs_on, pat_mem, pat_rgb};
      for (int i = 1; i <= DATA_LAT; i++) dl[i] <= dl[i-1];
    end
  end

  // Output stage: registers pins on pix_en, picks vmem data in mem mode, blanks colour.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      hsync <= ~HSYNC_POL;
      vsync <= ~VSYNC_POL;
      rgb_q <= '0;
    end else if (pix_en) begin
      valid <= tail[DLW-1];
      hsync <= tail[DLW-2] ? HSYNC_POL : ~HSYNC_POL;
      vsync <= tail[DLW-3] ? VSYNC_POL : ~VSYNC_POL;
      if (!tail[DLW-1])      rgb_q <= '0;
      else if (tail[DLW-4])  rgb_q <= vga_data;
      else                   rgb_q <= tail[RGB_W-1:0];
    end
  end

endmodule

// File: tb/tb_vga_ctrl_gen.sv
// Bench for vga_ctrl_gen: a reduced-timing head (mem/pattern modes, DATA_LAT=2)
// checked pixel by pixel through a scoreboard, and a tiny head with CLK_DIV=3.
module tb_vga_ctrl_gen;

  localparam int S_VAL1 = 0, S_HS1 = 1, S_VS1 = 2, S_VAL2 = 3, S_HS2 = 4, S_REQ2 = 5;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // head 1: H 128/8/16/8, V 40/2/2/4, CLK_DIV 1, DATA_LAT 2
  logic [1:0]  mode1;
  logic [23:0] solid1, vdata1, m1, m2;
  logic [6:0]  h1;
  logic [5:0]  v1;
  logic        req1, fs1, hs1, vs1, val1;
  logic [7:0]  r1, g1, b1;

  // head 2: H 8/2/2/2, V 4/1/1/1, CLK_DIV 3, DATA_LAT 1, active-high syncs
  logic [1:0]  mode2;
  logic [23:0] solid2, vdata2;
  logic [2:0]  h2;
  logic [1:0]  v2;
  logic        req2, fs2, hs2, vs2, val2;
  logic [7:0]  r2, g2, b2;

  vga_ctrl_gen #(
    .H_ACTIVE(128), .H_FP(8), .H_SYNC(16), .H_BP(8),
    .V_ACTIVE(40), .V_FP(2), .V_SYNC(2), .V_BP(4),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CLK_DIV(1), .DATA_LAT(2), .COLOR_W(8)
  ) u1 (
    .clock(clock), .reset(reset), .mode(mode1), .solid_rgb(solid1), .vga_data(vdata1),
    .h_addr(h1), .v_addr(v1), .pix_req(req1), .frame_start(fs1),
    .hsync(hs1), .vsync(vs1), .valid(val1), .vga_r(r1), .vga_g(g1), .vga_b(b1)
  );

  vga_ctrl_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CLK_DIV(3), .DATA_LAT(1), .COLOR_W(8)
  ) u2 (
    .clock(clock), .reset(reset), .mode(mode2), .solid_rgb(solid2), .vga_data(vdata2),
    .h_addr(h2), .v_addr(v2), .pix_req(req2), .frame_start(fs2),
    .hsync(hs2), .vsync(vs2), .valid(val2), .vga_r(r2), .vga_g(g2), .vga_b(b2)
  );

  function automatic logic [23:0] word(input int h, input int v);
    return {8'(v), 8'h5A, 8'(h)};
  endfunction

  function automatic logic [23:0] exp_rgb(input logic [1:0] m, input int h, input int v);
    logic [2:0] idx;
    case (m)
      2'b00: return word(h, v);
      2'b01: return solid1;
      2'b10: begin
        idx = 3'(h / 16);
        return {{8{~idx[1]}}, {8{~idx[2]}}, {8{~idx[0]}}};
      end
      default: return ((((h ^ v) >> 5) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
    endcase
  endfunction

  function automatic logic sig(input int s);
    case (s)
      S_VAL1:  return val1;
      S_HS1:   return hs1;
      S_VS1:   return vs1;
      S_VAL2:  return val2;
      S_HS2:   return hs2;
      default: return req2;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // vmem model: returns word(address) two pixel ticks after the request.
  always @(posedge clock) begin
    m1 <= word(int'(h1), int'(v1));
    m2 <= m1;
  end
  assign vdata1 = m2;
  assign vdata2 = 24'h0;

  // Scoreboard for head 1: push on request, pop on valid output.
  typedef struct {
    logic [23:0] rgb;
    int          h;
    int          v;
    int          t;
  } exp_t;

  exp_t        sbq[$];
  exp_t        e_new, e_got;
  int          tick1 = 0;
  logic [1:0]  fmode = 2'b00;
  logic [23:0] cap [0:127][0:39];

  always @(negedge clock) begin
    tick1++;
    if (reset) begin
      sbq.delete();
    end else begin
      if (fs1) fmode = mode1;
      if (req1) begin
        e_new.rgb = exp_rgb(fmode, int'(h1), int'(v1));
        e_new.h   = int'(h1);
        e_new.v   = int'(v1);
        e_new.t   = tick1;
        sbq.push_back(e_new);
      end
      if (val1) begin
        if (sbq.size() == 0) begin
          check("sb_unexpected_valid", {31'd0, val1}, 32'd0);
        end else begin
          e_got = sbq.pop_front();
          check("pix_rgb", {8'd0, r1, g1, b1}, {8'd0, e_got.rgb});
          check("pix_latency", tick1 - e_got.t, 32'd3);
          cap[e_got.h][e_got.v] = {r1, g1, b1};
        end
      end else begin
        check("blank_rgb1", {8'd0, r1, g1, b1}, 32'd0);
      end
    end
  end

  // Head 2: outputs may only change on pixel ticks (every 3rd clock); solid colour when valid.
  int          clk_n = 0;
  int          ref2 = 0;
  bit          have_ref = 1'b0;
  logic [26:0] prev2 = '0;

  always @(negedge clock) begin
    clk_n++;
    if (reset) begin
      have_ref = 1'b0;
    end else begin
      if ({val2, hs2, vs2, r2, g2, b2} !== prev2) begin
        if (!have_ref) begin
          ref2     = clk_n;
          have_ref = 1'b1;
        end else begin
          check("div3_change_phase", (clk_n - ref2) % 3, 32'd0);
        end
      end
      if (val2) check("solid_rgb2", {8'd0, r2, g2, b2}, {8'd0, solid2});
      else      check("blank_rgb2", {8'd0, r2, g2, b2}, 32'd0);
    end
    prev2 = {val2, hs2, vs2, r2, g2, b2};
  end

  task automatic wait_level(input int s, input logic lvl, input int limit, input string tag);
    int n = 0;
    while (sig(s) !== lvl && n < limit) begin
      @(negedge clock);
      n++;
    end
    check(tag, {31'd0, sig(s)}, {31'd0, lvl});
  endtask

  task automatic run_len(input int s, input logic lvl, input int limit, output int n);
    n = 0;
    while (sig(s) === lvl && n < limit) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic wait_fs1(input string tag);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (fs1 !== 1'b1 && n < 9000);
    check(tag, {31'd0, fs1}, 32'd1);
  endtask

  task automatic wait_fs2(input string tag);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (fs2 !== 1'b1 && n < 1000);
    check(tag, {31'd0, fs2}, 32'd1);
  endtask

  task automatic wait_req1_row(input int row, input string tag);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(req1 === 1'b1 && int'(v1) == row) && n < 9000);
    check(tag, {31'd0, (req1 === 1'b1 && int'(v1) == row)}, 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   n1;
    time  t0;
    time  t1;

    mode1  = 2'b00;
    mode2  = 2'b01;
    solid1 = 24'h123456;
    solid2 = 24'hA5C3E1;
    reset  = 1'b1;
    repeat (4) @(negedge clock);

    check("rst_ctrl1", {14'd0, hs1, vs1, val1, req1, fs1, h1, v1}, {14'd0, 5'b11000, 13'd0});
    check("rst_rgb1", {8'd0, r1, g1, b1}, 32'd0);
    check("rst_ctrl2", {22'd0, hs2, vs2, val2, req2, fs2, h2, v2}, 32'd0);
    check("rst_rgb2", {8'd0, r2, g2, b2}, 32'd0);

    reset = 1'b0;
    @(negedge clock);
    check("fs1_first_tick", {31'd0, fs1}, 32'd1);
    @(negedge clock);
    check("fs2_not_yet", {31'd0, fs2}, 32'd0);
    @(negedge clock);
    check("fs2_first_tick", {31'd0, fs2}, 32'd1);

    // Reset mid-line: outputs must drop to reset values without a clock edge.
    wait_req1_row(0, "reach_row0");
    n = 0;
    while (!(req1 === 1'b1 && int'(h1) == 100) && n < 400) begin
      @(negedge clock);
      n++;
    end
    check("reach_h100", {25'd0, h1}, 32'd100);
    #2 reset = 1'b1;
    #1;
    check("midrst_ctrl1", {14'd0, hs1, vs1, val1, req1, fs1, h1, v1}, {14'd0, 5'b11000, 13'd0});
    check("midrst_rgb1", {8'd0, r1, g1, b1}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("fs1_after_midrst", {31'd0, fs1}, 32'd1);
    t0 = $time;

    // Frame A, mem mode: line structure and sync alignment at the pins.
    wait_level(S_VAL1, 1'b1, 400, "val1_rise");
    run_len(S_VAL1, 1'b1, 1000, n);
    check("valid_per_line", n, 32'd128);
    run_len(S_HS1, 1'b1, 1000, n);
    check("hfp_after_valid", n, 32'd8);
    run_len(S_HS1, 1'b0, 1000, n);
    check("hsync_width", n, 32'd16);
    run_len(S_HS1, 1'b1, 1000, n1);
    check("line_len", n + n1, 32'd160);
    wait_level(S_VS1, 1'b0, 9000, "vs1_fall");
    run_len(S_VS1, 1'b0, 1000, n);
    check("vsync_width", n, 32'd320);
    check("mem_col5_row0", {8'd0, cap[5][0]}, 32'h005A05);
    check("mem_last_pixel", {8'd0, cap[127][39]}, 32'h275A7F);

    // Frame B: checkerboard.
    mode1 = 2'b11;
    wait_fs1("fs1_frame_b");
    t1 = $time;
    check("frame_period", 32'((t1 - t0) / 10), 32'd7680);
    wait_req1_row(36, "reach_row36_b");
    check("chk_0_0", {8'd0, cap[0][0]}, 32'h000000);
    check("chk_32_0", {8'd0, cap[32][0]}, 32'hFFFFFF);
    check("chk_32_32", {8'd0, cap[32][32]}, 32'h000000);
    check("chk_0_32", {8'd0, cap[0][32]}, 32'hFFFFFF);

    // Frame C: solid, switching to bars at line 20 must not affect this frame.
    mode1 = 2'b01;
    wait_fs1("fs1_frame_c");
    t0 = $time;
    check("frame_period_c", 32'((t0 - t1) / 10), 32'd7680);
    wait_req1_row(20, "reach_row20_c");
    mode1 = 2'b10;
    wait_fs1("fs1_frame_d");
    check("solid_0_0", {8'd0, cap[0][0]}, 32'h123456);
    check("solid_after_switch", {8'd0, cap[64][39]}, 32'h123456);
    check("solid_row25", {8'd0, cap[127][25]}, 32'h123456);

    // Frame D: colour bars.
    wait_req1_row(2, "reach_row2_d");
    check("bar_col0", {8'd0, cap[0][0]}, 32'hFFFFFF);
    check("bar_col16", {8'd0, cap[16][0]}, 32'hFFFF00);
    check("bar_col48", {8'd0, cap[48][0]}, 32'h00FF00);
    check("bar_col112", {8'd0, cap[112][0]}, 32'h000000);
    check("bar_col127_row1", {8'd0, cap[127][1]}, 32'h000000);

    // Head 2: divided pixel clock.
    wait_fs2("fs2_a");
    t0 = $time;
    run_len(S_REQ2, 1'b1, 10, n);
    check("req2_high_len", n, 32'd1);
    run_len(S_REQ2, 1'b0, 10, n1);
    check("req2_spacing", n + n1, 32'd3);
    check("h2_step", {29'd0, h2}, 32'd1);
    wait_fs2("fs2_b");
    t1 = $time;
    check("frame2_period", 32'((t1 - t0) / 10), 32'd294);
    wait_level(S_HS2, 1'b1, 200, "hs2_rise");
    run_len(S_HS2, 1'b1, 100, n);
    check("hsync2_width", n, 32'd6);
    wait_level(S_VAL2, 1'b1, 400, "val2_rise");
    run_len(S_VAL2, 1'b1, 100, n);
    check("valid2_per_line", n, 32'd24);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
